// File: rtl/gf180mcu_osu_sc_12t_bufchain_meas.sv
// Launch/capture delay monitor for a 12T buffer characterisation chain.
// Toggles the chain input, times each synchronised round trip and accumulates NSAMP trips.
module gf180mcu_osu_sc_12t_bufchain_meas #(
  parameter int CNT_W   = 8,
  parameter int ACC_W   = 16,
  parameter int NSAMP_W = 4
) (
  input  logic               CLK,
  input  logic               RN,
  input  logic               START,
  input  logic [NSAMP_W-1:0] NSAMP,
  input  logic               CHAIN_IN,
  output logic               CHAIN_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic [ACC_W-1:0]   RESULT,
  output logic               TIMEOUT_ERR
);

  localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_FINISH
  } state_t;

  state_t             state;
  logic               s1;
  logic               s2;
  logic [CNT_W-1:0]   trip_cnt;
  logic [NSAMP_W-1:0] samp_cnt;
  logic [NSAMP_W-1:0] nsamp_lat;
  logic [ACC_W-1:0]   acc;

  logic [SUM_W-1:0]   sum_ext;
  logic [ACC_W-1:0]   acc_sat;
  logic [NSAMP_W-1:0] samp_inc;

  // Any carry beyond ACC_W bits means the accumulator must pin at all-ones.
  always_comb begin
    sum_ext  = SUM_W'(acc) + SUM_W'(trip_cnt);
    acc_sat  = (|(sum_ext >> ACC_W)) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    samp_inc = samp_cnt + NSAMP_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state       <= ST_IDLE;
      s1          <= 1'b0;
      s2          <= 1'b0;
      trip_cnt    <= '0;
      samp_cnt    <= '0;
      nsamp_lat   <= '0;
      acc         <= '0;
      CHAIN_OUT   <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      RESULT      <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      s1   <= CHAIN_IN;
      s2   <= s1;
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            TIMEOUT_ERR <= 1'b0;
            RESULT      <= '0;
            acc         <= '0;
            samp_cnt    <= '0;
            if (NSAMP != '0) begin
              nsamp_lat <= NSAMP;
              BUSY      <= 1'b1;
              state     <= ST_ARM;
            end else begin
              DONE  <= 1'b1;
              state <= ST_FINISH;
            end
          end
        end
        ST_ARM: begin
          // Launch only once the far end has settled to the current level.
          if (s2 == CHAIN_OUT) begin
            CHAIN_OUT <= ~CHAIN_OUT;
            trip_cnt  <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (s2 == CHAIN_OUT) begin
            acc      <= acc_sat;
            samp_cnt <= samp_inc;
            if (samp_inc == nsamp_lat) begin
              RESULT <= acc_sat;
              DONE   <= 1'b1;
              BUSY   <= 1'b0;
              state  <= ST_FINISH;
            end else begin
              state <= ST_ARM;
            end
          end else if (trip_cnt == {CNT_W{1'b1}}) begin
            TIMEOUT_ERR <= 1'b1;
            RESULT      <= acc;
            DONE        <= 1'b1;
            BUSY        <= 1'b0;
            state       <= ST_FINISH;
          end else begin
            trip_cnt <= trip_cnt + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_bufchain_meas.sv
// Directed bench for the buffer-chain delay monitor, with a registered delay line modelling the chain.
module tb_gf180mcu_osu_sc_12t_bufchain_meas;

  logic        clk;
  logic        rn;
  logic        start;
  logic [3:0]  nsamp;
  logic        chain_in;
  logic        chain_out;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        timeout_err;

  logic        start2;
  logic [3:0]  nsamp2;
  logic        chain_in2;
  logic        chain_out2;
  logic        busy2;
  logic        done2;
  logic [7:0]  result2;
  logic        timeout_err2;

  int          delay;
  bit          stuck;
  logic [127:0] dl;
  logic [127:0] dl2;

  int tests_run;
  int tests_failed;

  gf180mcu_osu_sc_12t_bufchain_meas u_dut (
    .CLK(clk), .RN(rn), .START(start), .NSAMP(nsamp), .CHAIN_IN(chain_in),
    .CHAIN_OUT(chain_out), .BUSY(busy), .DONE(done), .RESULT(result),
    .TIMEOUT_ERR(timeout_err)
  );

  gf180mcu_osu_sc_12t_bufchain_meas #(.ACC_W(8)) u_sat (
    .CLK(clk), .RN(rn), .START(start2), .NSAMP(nsamp2), .CHAIN_IN(chain_in2),
    .CHAIN_OUT(chain_out2), .BUSY(busy2), .DONE(done2), .RESULT(result2),
    .TIMEOUT_ERR(timeout_err2)
  );

  always #5 clk = ~clk;

  // Chain model: each stage is one registered cycle of extra delay.
  always @(posedge clk) begin
    if (!rn) begin
      dl  <= '0;
      dl2 <= '0;
    end else begin
      dl  <= {dl[126:0], chain_out};
      dl2 <= {dl2[126:0], chain_out2};
    end
  end

  always_comb begin
    chain_in = 1'b0;
    if (!stuck) chain_in = (delay == 0) ? chain_out : dl[delay-1];
    chain_in2 = dl2[99];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rn = 1'b0;
    tick();
    rn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({chain_out, busy, done, result, timeout_err} !== 20'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {chain_out, busy, done, result, timeout_err});
    end
    tests_run++;
    if ({chain_out2, busy2, done2, result2, timeout_err2} !== 12'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs_sat: got %b expected all zero",
               {chain_out2, busy2, done2, result2, timeout_err2});
    end
  endtask

  task automatic test_loopback();
    int n_done;
    logic c_busy, c_te, c_co;
    logic [15:0] c_res;
    n_done = 0; c_busy = 1'bx; c_te = 1'bx; c_co = 1'bx; c_res = 'x;
    delay = 0; stuck = 0;
    start = 1'b1; nsamp = 4'd1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) begin
        n_done++;
        c_busy = busy; c_te = timeout_err; c_co = chain_out; c_res = result;
      end
    end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL loop_done_count: got %0d expected 1", n_done); end
    tests_run++;
    if (c_res !== 16'd2) begin tests_failed++; $display("[TB] FAIL loop_result: got %0d expected 2", c_res); end
    tests_run++;
    if (c_te !== 1'b0) begin tests_failed++; $display("[TB] FAIL loop_timeout: got %b expected 0", c_te); end
    tests_run++;
    if (c_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL loop_busy_on_done: got %b expected 0", c_busy); end
    tests_run++;
    if (c_co !== 1'b1) begin tests_failed++; $display("[TB] FAIL loop_chain_out: got %b expected 1", c_co); end
  endtask

  task automatic test_zero_nsamp();
    start = 1'b1; nsamp = 4'd0;
    tick();
    start = 1'b0;
    tests_run++;
    if ({done, busy, result, chain_out} !== {1'b1, 1'b0, 16'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL zero_nsamp_done: got done=%b busy=%b result=%0d chain_out=%b expected 1 0 0 1",
               done, busy, result, chain_out);
    end
    tick();
    tests_run++;
    if ({done, chain_out} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL zero_nsamp_after: got done=%b chain_out=%b expected 0 1", done, chain_out);
    end
  endtask

  task automatic test_delay5();
    int n_done, ntog;
    logic prev;
    logic [7:0] seq;
    logic [15:0] c_res;
    n_done = 0; ntog = 0; seq = '0; c_res = 'x;
    do_reset();
    delay = 5; stuck = 0;
    start = 1'b1; nsamp = 4'd4;
    tick();
    start = 1'b0;
    prev = chain_out;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (chain_out !== prev) begin
        if (ntog < 8) seq[ntog] = chain_out;
        ntog++;
        prev = chain_out;
      end
      if (done) begin n_done++; c_res = result; end
    end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL d5_done_count: got %0d expected 1", n_done); end
    tests_run++;
    if (ntog != 4) begin tests_failed++; $display("[TB] FAIL d5_launches: got %0d expected 4", ntog); end
    tests_run++;
    if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b1010) begin
      tests_failed++;
      $display("[TB] FAIL d5_launch_levels: got %b expected 1010", {seq[0], seq[1], seq[2], seq[3]});
    end
    tests_run++;
    if (c_res !== 16'd28) begin tests_failed++; $display("[TB] FAIL d5_result: got %0d expected 28", c_res); end
    tests_run++;
    if (chain_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL d5_final_level: got %b expected 0", chain_out); end
  endtask

  task automatic test_timeout();
    int k;
    bit found;
    do_reset();
    stuck = 1;
    start = 1'b1; nsamp = 4'd3;
    tick();
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (chain_out === 1'b1) found = 1;
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL to_launch: got no launch expected chain_out=1"); end
    k = 0; found = 0;
    while (!found && k < 400) begin
      tick();
      k++;
      if (done === 1'b1) found = 1;
    end
    tests_run++;
    if (k != 256) begin tests_failed++; $display("[TB] FAIL to_latency: got %0d cycles expected 256", k); end
    tests_run++;
    if ({timeout_err, busy, result} !== {1'b1, 1'b0, 16'd0}) begin
      tests_failed++;
      $display("[TB] FAIL to_flags: got te=%b busy=%b result=%0d expected 1 0 0", timeout_err, busy, result);
    end
    tick();
    tests_run++;
    if ({timeout_err, done} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL to_hold: got te=%b done=%b expected 1 0", timeout_err, done);
    end
    start = 1'b1; nsamp = 4'd3;
    tick();
    start = 1'b0;
    tests_run++;
    if ({timeout_err, busy} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL to_clear_on_start: got te=%b busy=%b expected 0 1", timeout_err, busy);
    end
  endtask

  task automatic test_reset_midrun();
    int ntog, n_done;
    logic prev;
    logic [15:0] c_res;
    do_reset();
    stuck = 0; delay = 3;
    start = 1'b1; nsamp = 4'd15;
    tick();
    start = 1'b0;
    ntog = 0; prev = chain_out;
    for (int i = 0; i < 200 && ntog < 7; i++) begin
      tick();
      if (chain_out !== prev) begin ntog++; prev = chain_out; end
    end
    tests_run++;
    if (ntog != 7) begin tests_failed++; $display("[TB] FAIL rst_reach_trip7: got %0d launches expected 7", ntog); end
    tick();
    tick();
    rn = 1'b0;
    tick();
    rn = 1'b1;
    tests_run++;
    if ({chain_out, busy, done, result, timeout_err} !== 20'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_outputs: got %b expected all zero",
               {chain_out, busy, done, result, timeout_err});
    end
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) n_done++;
    end
    tests_run++;
    if (n_done != 0) begin tests_failed++; $display("[TB] FAIL rst_no_done: got %0d expected 0", n_done); end
    start = 1'b1; nsamp = 4'd2;
    tick();
    start = 1'b0;
    c_res = 'x;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done) begin n_done++; c_res = result; end
    end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL rst_rerun_done: got %0d expected 1", n_done); end
    tests_run++;
    if (c_res !== 16'd10) begin tests_failed++; $display("[TB] FAIL rst_rerun_result: got %0d expected 10", c_res); end
  endtask

  task automatic test_saturation();
    int n_done, ntog;
    logic prev, busy_at_restart;
    logic [7:0] c_res;
    logic c_te;
    n_done = 0; ntog = 0; c_res = 'x; c_te = 1'bx; busy_at_restart = 1'bx;
    start2 = 1'b1; nsamp2 = 4'd3;
    tick();
    start2 = 1'b0;
    prev = chain_out2;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (chain_out2 !== prev) begin ntog++; prev = chain_out2; end
      if (done2) begin n_done++; c_res = result2; c_te = timeout_err2; end
      if (i == 30) begin busy_at_restart = busy2; start2 = 1'b1; nsamp2 = 4'd1; end
      if (i == 31) start2 = 1'b0;
    end
    tests_run++;
    if (busy_at_restart !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_busy_mid: got %b expected 1", busy_at_restart); end
    tests_run++;
    if (n_done != 1) begin tests_failed++; $display("[TB] FAIL sat_done_count: got %0d expected 1", n_done); end
    tests_run++;
    if (ntog != 3) begin tests_failed++; $display("[TB] FAIL sat_launches: got %0d expected 3", ntog); end
    tests_run++;
    if (c_res !== 8'd255) begin tests_failed++; $display("[TB] FAIL sat_result: got %0d expected 255", c_res); end
    tests_run++;
    if (c_te !== 1'b0) begin tests_failed++; $display("[TB] FAIL sat_timeout: got %b expected 0", c_te); end
  endtask

  initial begin
    clk = 1'b0; rn = 1'b1; start = 1'b0; nsamp = '0;
    start2 = 1'b0; nsamp2 = '0;
    delay = 0; stuck = 0;
    tests_run = 0; tests_failed = 0;
    tick();
    test_reset();
    test_loopback();
    test_zero_nsamp();
    test_delay5();
    test_timeout();
    test_reset_midrun();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
